// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide.
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_en,
  input  logic             lo_en,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t               state_r;
  logic [1:0]           op_r;
  logic                 neg_q_r;
  logic                 neg_rem_r;
  logic [WIDTH-1:0]     opnd_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CW-1:0]        cnt_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 rs_neg_s;
  logic                 rt_neg_s;
  logic [WIDTH-1:0]     rs_mag_s;
  logic [WIDTH-1:0]     rt_mag_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic                 q_bit_s;
  logic [2*WIDTH-1:0]   step_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quot_s;
  logic [WIDTH-1:0]     rem_s;

  // Operand magnitudes, one datapath step, and final sign correction
  always_comb begin
    rs_neg_s    = ~op[0] & rs_data[WIDTH-1];
    rt_neg_s    = ~op[0] & rt_data[WIDTH-1];
    rs_mag_s    = rs_neg_s ? (~rs_data + {{(WIDTH-1){1'b0}}, 1'b1}) : rs_data;
    rt_mag_s    = rt_neg_s ? (~rt_data + {{(WIDTH-1){1'b0}}, 1'b1}) : rt_data;

    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  {1'b0, (acc_r[0] ? opnd_r : {WIDTH{1'b0}})};
    // A zero divisor always "fits", giving an all-ones quotient and |rs| remainder
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    q_bit_s     = (div_shift_s >= {1'b0, opnd_r});

    if (op_r[1]) begin
      step_s = {(q_bit_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0]),
                acc_r[WIDTH-2:0], q_bit_s};
    end else begin
      step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end

    prod_s = neg_q_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
    quot_s = neg_q_r ? (~acc_r[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                     : acc_r[WIDTH-1:0];
    rem_s  = neg_rem_r ? (~acc_r[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                       : acc_r[2*WIDTH-1:WIDTH];
  end

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_r   <= IDLE;
      op_r      <= 2'd0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      opnd_r    <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      cnt_r     <= {CW{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r      <= op;
            neg_rem_r <= op[1] & rs_neg_s;
            neg_q_r   <= (rs_neg_s ^ rt_neg_s) & ~(op[1] & (rt_data == {WIDTH{1'b0}}));
            opnd_r    <= op[1] ? rt_mag_s : rs_mag_s;
            acc_r     <= {{WIDTH{1'b0}}, (op[1] ? rs_mag_s : rt_mag_s)};
            cnt_r     <= {CW{1'b0}};
            busy_r    <= 1'b1;
            state_r   <= RUN;
          end else begin
            if (hi_en) hi_r <= rs_data;
            if (lo_en) lo_r <= rs_data;
          end
        end
        RUN: begin
          acc_r <= step_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CW'(WIDTH-1)) state_r <= FIN;
        end
        FIN: begin
          if (op_r[1]) begin
            hi_r <= rem_s;
            lo_r <= quot_s;
          end else begin
            hi_r <= prod_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_s[WIDTH-1:0];
          end
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign hi_out = hi_r;
  assign lo_out = lo_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: issued operations queue their expected
// HI/LO and launch time; a monitor pops and compares on every done pulse.
module tb_mips_muldiv;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_en;
  logic        lo_en;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic done_prev = 1'b0;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hi_en(hi_en), .lo_en(lo_en),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compares each completed operation and the one-cycle done pulse
  always @(negedge clk) begin
    if (done_prev) chk("done_pulse", {31'd0, done}, 32'd0);
    if (rst_b && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("hi", hi_out, e.hi);
        chk("lo", lo_out, e.lo);
        chk("latency", 32'(cyc - e.cyc), 32'd34);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
    done_prev <= rst_b & done;
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    exp_t e;
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    e.hi = eh; e.lo = el; e.cyc = cyc;
    if (push) q.push_back(e);
    @(negedge clk);
    start = 1'b0; hi_en = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      chk("timeout", 32'd1, 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0; start = 1'b0; op = 2'd0; rs_data = 32'd0; rt_data = 32'd0;
    hi_en = 1'b0; lo_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1); wait_idle();
    issue(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1); wait_idle();
    issue(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1); wait_idle();
    issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1); wait_idle();
    issue(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b1); wait_idle();
    issue(2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1); wait_idle();
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1); wait_idle();

    // MTHI in idle
    @(negedge clk);
    hi_en = 1'b1; rs_data = 32'hCAFEBABE;
    @(negedge clk);
    hi_en = 1'b0;
    chk("mthi_hi", hi_out, 32'hCAFEBABE);
    chk("mthi_lo_hold", lo_out, 32'h80000000);

    // start and hi_en together: start wins
    @(negedge clk);
    hi_en = 1'b1;
    issue(2'b01, 32'h0BADF00D, 32'h00000001, 32'h00000000, 32'h0BADF00D, 1'b1);
    chk("start_beats_mthi", hi_out, 32'hCAFEBABE);
    wait_idle();

    // MTLO and a second start during DIVU are ignored
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    repeat (5) @(negedge clk);
    lo_en = 1'b1; rs_data = 32'h55;
    @(negedge clk);
    lo_en = 1'b0; start = 1'b1; op = 2'b01; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_dropped", lo_out, 32'h0BADF00D);
    wait_idle();

    // Reset mid-DIV aborts without touching HI/LO
    issue(2'b10, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
    repeat (8) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi_out, 32'd0);
    chk("abort_lo", lo_out, 32'd0);
    repeat (40) @(negedge clk);

    issue(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1); wait_idle();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Iterative multiply/divide unit holding the architectural HI and LO registers; sits directly downstream of instruction decode, alongside the ALU in execute.
- Executes MULT, MULTU, DIV, DIVU over multiple cycles and services MTHI/MTLO writes.
- Drives hi_out/lo_out back to the writeback mux for MFHI/MFLO.
- Asserts busy so the pipeline control stalls any HI/LO access until the result lands.

Parameters:
WIDTH, 32, operand and HI/LO register width (iteration count equals WIDTH)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_b  input  1  synchronous, active-low reset
start  input  1  launch an operation this cycle
op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start
rs_data  input  WIDTH  multiplicand/dividend; also MTHI/MTLO source
rt_data  input  WIDTH  multiplier/divisor
hi_en  input  1  MTHI: write rs_data to HI
lo_en  input  1  MTLO: write rs_data to LO
hi_out  output  WIDTH  current HI register
lo_out  output  WIDTH  current LO register
busy  output  1  operation in flight
done  output  1  one-cycle pulse, HI/LO just updated by an operation

Behaviour:
- Reset (rst_b=0 at an edge): state=IDLE, HI=0, LO=0, busy=0, done=0, iteration counter=0. Reset mid-operation aborts it; no partial result reaches HI/LO.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On start=1: latch op, form magnitudes (signed ops take |rs|,|rt| and record result signs; unsigned ops use operands as-is), clear the accumulator, counter=0, go to RUN.
- RUN:
  - One radix-2 step per cycle. Multiply is shift-add into a 2*WIDTH accumulator. Divide is restoring shift-subtract, producing one quotient bit and a partial remainder.
  - Counter increments each cycle. After WIDTH steps (counter==WIDTH-1 at the edge), go to FIN.
- FIN:
  - Apply sign correction. MULT: negate the 64-bit product if signs differ. DIV: negate quotient if signs differ; remainder takes the dividend's sign.
  - Write HI/LO. Multiply: HI=upper, LO=lower. Divide: HI=remainder, LO=quotient.
  - Go to IDLE; done=1 for the following cycle only.
- Latency: start at edge t0; RUN occupies edges t1..tWIDTH; FIN write at edge tWIDTH+1. With WIDTH=32, HI/LO and done are valid 33 edges after start.
- busy=1 whenever state!=IDLE; it is a registered output and deasserts in the same cycle done asserts.
- start while busy: ignored, with no effect on the in-flight operation.
- hi_en/lo_en:
  - Honoured only in IDLE with start=0; the write is visible on hi_out/lo_out the next cycle.
  - Dropped while busy.
  - If start and hi_en/lo_en are asserted together, start wins and the MT write is dropped.
  - hi_en and lo_en together write rs_data to both.
- Divide by zero (rt_data=0, any divide op): HI=rs_data, LO={WIDTH{1}}, normal latency, no exception.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MULT/MULTU never overflow; the full 2*WIDTH product is kept.
- HI/LO hold their value in all cycles not listed above.
- op is ignored when start=0.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy=1 the cycle after start; 33 edges later HI=0xFFFFFFFE, LO=0x00000001, done pulses exactly one cycle, busy=0.
- MULT rs=0xFFFFFFFD (-3) rt=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=100 rt=7 -> LO=14, HI=2.
- DIV rs=0x00001234 rt=0 -> HI=0x00001234, LO=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xCAFEBABE in IDLE -> hi_out=0xCAFEBABE next cycle. MTLO and a second start issued mid-DIVU -> both ignored; final HI/LO are the DIVU result. start+hi_en in the same cycle -> HI is not written by MTHI.
- rst_b=0 for one edge on cycle 10 of a DIV -> next cycle busy=0, done=0, HI=LO=0. Then MULTU 3*5 -> LO=15, HI=0 with full latency.
